fifo_uart_tx: RTL and testbench

Drains bytes from the 64-deep byte FIFO and serialises each one onto an asynchronous 8N1 serial line. It sits directly downstream of the FIFO. It drives the FIFO's read strobe, captures the FIFO's registered output byte, and shifts it out LSB-first at a fixed baud rate derived from the system clock. Flow control is implicit: a new byte is popped only when the line is idle, `enable` is high and the FIFO is not empty.

---
 rtl/fifo_uart_tx.sv | 156 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream byte FIFO and sends each one
// as an 8N1 frame, LSB first: one start bit, eight data bits, one stop bit.
// A frame takes 10*CLKS_PER_BIT clocks. The read/load handshake adds an
// idle-high gap of at least 3 clocks between consecutive frames.
// CLKS_PER_BIT must be at least 2.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shiftReg_q, shiftReg_d;
  logic             tx_q;
  logic             fifoRd_q;
  logic             busy_q;
  logic             byteDone_q;
  logic             bitEnd;
  logic             stopPenult;

  // Detect the last clock of the current serial bit, and the clock just before the end of the stop bit.
  always_comb begin
    bitEnd     = (baudCnt_q == CNT_LAST);
    stopPenult = (state_q == STOP) && (baudCnt_q == CNT_PENULT);
  end

  // Next values for the baud counter, bit index and shift register; only the serialising states advance them.
  always_comb begin
    baudCnt_d  = baudCnt_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    case (state_q)
      LOAD: begin
        baudCnt_d  = '0;
        bitIdx_d   = 3'd0;
        shiftReg_d = fifo_data;
      end
      START, STOP: begin
        baudCnt_d = bitEnd ? '0 : baudCnt_q + CNT_W'(1);
      end
      DATA: begin
        baudCnt_d = bitEnd ? '0 : baudCnt_q + CNT_W'(1);
        if (bitEnd) begin
          bitIdx_d   = bitIdx_q + 3'd1;
          shiftReg_d = {1'b0, shiftReg_q[7:1]};
        end
      end
      default: begin
        baudCnt_d = '0;
      end
    endcase
  end

  // Datapath registers; reset clears them so no partial frame can survive.
  always_ff @(posedge clk) begin
    if (reset) begin
      baudCnt_q  <= '0;
      bitIdx_q   <= 3'd0;
      shiftReg_q <= 8'h00;
    end else begin
      baudCnt_q  <= baudCnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
    end
  end

  // Frame sequencer; every output is set one clock ahead so that it is registered in the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      fifoRd_q   <= 1'b0;
      busy_q     <= 1'b0;
      byteDone_q <= 1'b0;
    end else begin
      fifoRd_q   <= 1'b0;
      byteDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (enable && !fifo_empty) begin
            state_q  <= READ;
            fifoRd_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        READ: begin
          state_q <= LOAD;
        end
        LOAD: begin
          state_q <= START;
          tx_q    <= 1'b0;
        end
        START: begin
          if (bitEnd) begin
            state_q <= DATA;
            tx_q    <= shiftReg_q[0];
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shiftReg_q[1];
            end
          end
        end
        STOP: begin
          if (stopPenult) begin
            byteDone_q <= 1'b1;
          end
          if (bitEnd) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd   = fifoRd_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = byteDone_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx at CLKS_PER_BIT=4 from a FIFO model.
// Every transmitted frame is compared, clock by clock, with the 8N1 waveform
// that the byte should produce.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       byte_done;

  int vectors = 0;
  int errors = 0;
  int cycle = 0;

  logic [7:0] mem [0:255];
  logic [7:0] wrPtr = 8'd0;
  logic [7:0] rdPtr = 8'd0;
  int         popCount = 0;
  logic       underflow = 1'b0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd(fifo_rd),
    .tx(tx),
    .busy(busy),
    .byte_done(byte_done)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Counts clock edges so that event latencies can be measured.
  always @(posedge clk) cycle <= cycle + 1;

  // The upstream FIFO: it pops on a read strobe and presents the byte as a registered output.
  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      if (wrPtr != rdPtr) begin
        fifo_data <= mem[rdPtr];
        rdPtr     <= rdPtr + 8'd1;
        popCount  <= popCount + 1;
      end else begin
        underflow <= 1'b1;
      end
    end
  end

  assign fifo_empty = (wrPtr == rdPtr);

  // Expected line level for bit slot idx of a frame: start, D0..D7, stop.
  function automatic logic frameBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    mem[wrPtr] = b;
    wrPtr = wrPtr + 8'd1;
  endtask

  // Wait for the read strobe, then follow one frame clock by clock.
  // dropEnAt drops enable after frame clock k; resetAt pulses reset after clock k, ending the frame early.
  task automatic expectFrame(input logic [7:0] b, input int dropEnAt, input int resetAt,
                             output int rdCyc, output int doneCyc);
    logic [7:0] rx;
    bit found;
    rdCyc = -1;
    doneCyc = -1;
    found = 0;
    rx = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fifo_rd === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checkOutput("rd_timeout", 32'd0, 32'd1);
      return;
    end
    rdCyc = cycle;
    checkOutput("read_busy", 32'(busy), 32'd1);
    checkOutput("read_tx", 32'(tx), 32'd1);
    @(negedge clk);
    checkOutput("load_rd", 32'(fifo_rd), 32'd0);
    checkOutput("load_tx", 32'(tx), 32'd1);
    checkOutput("load_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      checkOutput("frame_tx", 32'(tx), 32'(frameBit(b, k / CPB)));
      checkOutput("frame_done", 32'(byte_done), (k == 10 * CPB - 1) ? 32'd1 : 32'd0);
      checkOutput("frame_busy", 32'(busy), 32'd1);
      checkOutput("frame_rd", 32'(fifo_rd), 32'd0);
      if ((k % CPB) == CPB / 2 && (k / CPB) >= 1 && (k / CPB) <= 8) rx[k/CPB-1] = tx;
      if (k == 10 * CPB - 1) doneCyc = cycle;
      if (k == dropEnAt) enable = 1'b0;
      if (k == resetAt) begin
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rd", 32'(fifo_rd), 32'd0);
        checkOutput("rst_done", 32'(byte_done), 32'd0);
        reset = 1'b0;
        return;
      end
    end
    @(negedge clk);
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_tx", 32'(tx), 32'd1);
    checkOutput("post_done", 32'(byte_done), 32'd0);
    checkOutput("decoded", 32'(rx), 32'(b));
  endtask

  initial begin
    int rdCyc, doneCyc, prevDone, relCyc, enCyc, pops;
    logic [7:0] b0, r1, r2;
    logic [7:0] burst [6];

    // Reset held with enable high and a byte waiting.
    b0 = 8'($urandom);
    applyStimulus(b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_hold_tx", 32'(tx), 32'd1);
      checkOutput("rst_hold_rd", 32'(fifo_rd), 32'd0);
      checkOutput("rst_hold_busy", 32'(busy), 32'd0);
      checkOutput("rst_hold_done", 32'(byte_done), 32'd0);
    end
    reset = 1'b0;
    relCyc = cycle;
    #1;
    checkOutput("rel_tx", 32'(tx), 32'd1);
    checkOutput("rel_rd", 32'(fifo_rd), 32'd0);
    checkOutput("rel_busy", 32'(busy), 32'd0);
    expectFrame(b0, -1, -1, rdCyc, doneCyc);
    checkOutput("first_rd_cycle", 32'(rdCyc), 32'(relCyc + 1));

    // One byte, 0xA5. byte_done falls in the 42nd clock when the read clock counts as the first.
    pops = popCount;
    applyStimulus(8'hA5);
    expectFrame(8'hA5, -1, -1, rdCyc, doneCyc);
    checkOutput("done_latency", 32'(doneCyc - rdCyc), 32'd41);
    checkOutput("single_pops", 32'(popCount - pops), 32'd1);

    // Back-to-back bytes, each read strobe two clocks after the previous byte_done.
    pops = popCount;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h3C);
    expectFrame(8'h00, -1, -1, rdCyc, doneCyc);
    prevDone = doneCyc;
    expectFrame(8'hFF, -1, -1, rdCyc, doneCyc);
    checkOutput("b2b_gap1", 32'(rdCyc - prevDone), 32'd2);
    prevDone = doneCyc;
    expectFrame(8'h3C, -1, -1, rdCyc, doneCyc);
    checkOutput("b2b_gap2", 32'(rdCyc - prevDone), 32'd2);
    checkOutput("b2b_empty", 32'(fifo_empty), 32'd1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checkOutput("b2b_no_rd", 32'(fifo_rd), 32'd0);
    end
    checkOutput("b2b_pops", 32'(popCount - pops), 32'd3);

    // An empty FIFO with enable high stays idle.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("empty_no_rd", 32'(fifo_rd), 32'd0);
      checkOutput("empty_tx", 32'(tx), 32'd1);
    end

    // Enable low holds back a waiting byte; raising enable starts it.
    enable = 1'b0;
    applyStimulus(8'h55);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("gated_no_rd", 32'(fifo_rd), 32'd0);
    end
    enable = 1'b1;
    enCyc = cycle;
    expectFrame(8'h55, -1, -1, rdCyc, doneCyc);
    checkOutput("enable_rd_cycle", 32'(rdCyc), 32'(enCyc + 1));

    // Enable dropped during D3 of 0x81: the frame finishes, and no further byte is read.
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    applyStimulus(8'h81);
    applyStimulus(r1);
    applyStimulus(r2);
    expectFrame(8'h81, 4 * CPB + 1, -1, rdCyc, doneCyc);
    pops = popCount;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("drop_no_rd", 32'(fifo_rd), 32'd0);
    end
    checkOutput("drop_pops", 32'(popCount - pops), 32'd0);

    // Reset during D5 of r1, then r2 goes out as a clean frame.
    enable = 1'b1;
    expectFrame(r1, -1, 6 * CPB + 1, rdCyc, doneCyc);
    relCyc = cycle;
    expectFrame(r2, -1, -1, rdCyc, doneCyc);
    checkOutput("post_rst_rd_cycle", 32'(rdCyc), 32'(relCyc + 1));

    // A burst of random bytes, sent back to back.
    for (int i = 0; i < 6; i++) begin
      burst[i] = 8'($urandom);
      applyStimulus(burst[i]);
    end
    prevDone = -1;
    for (int i = 0; i < 6; i++) begin
      expectFrame(burst[i], -1, -1, rdCyc, doneCyc);
      if (i > 0) checkOutput("burst_gap", 32'(rdCyc - prevDone), 32'd2);
      prevDone = doneCyc;
    end
    checkOutput("no_underflow", 32'(underflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
